// File: rtl/io_port.sv
// Core IO port: a TX FIFO fed by IO writes and drained by an external sink,
// and an RX FIFO filled by an external source and drained by IO reads.
module io_port #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ioW,
  input  logic                     ioR,
  input  logic [15:0]              wdata,
  output logic [15:0]              rdata,
  output logic                     stall,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 16;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];

  logic [PW-1:0] tx_wr, tx_rd;
  logic [PW-1:0] rx_wr, rx_rd;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

  // Occupancy flags from the extra pointer MSB
  always_comb begin
    tx_empty = (tx_wr == tx_rd);
    tx_full  = (tx_wr[AW-1:0] == tx_rd[AW-1:0]) && (tx_wr[AW] != tx_rd[AW]);
    rx_empty = (rx_wr == rx_rd);
    rx_full  = (rx_wr[AW-1:0] == rx_rd[AW-1:0]) && (rx_wr[AW] != rx_rd[AW]);
  end

  // A stall blocks both core-side operations, using pre-edge flags only
  always_comb begin
    stall   = (ioW & tx_full) | (ioR & rx_empty);
    tx_push = ioW & ~stall;
    rx_pop  = ioR & ~stall;
    tx_pop  = ~tx_empty & out_ready;
    rx_push = in_valid & ~rx_full;
  end

  always_comb begin
    out_valid = ~tx_empty;
    out_data  = tx_mem[tx_rd[AW-1:0]];
    in_ready  = ~rx_full;
    rdata     = rx_empty ? DW'(0) : rx_mem[rx_rd[AW-1:0]];
    tx_count  = tx_wr - tx_rd;
    rx_count  = rx_wr - rx_rd;
  end

  // Pointer state; storage below is deliberately left without reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= wdata;
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_io_port.sv
// Randomized and directed bench for io_port: queue-based reference model with
// a scoreboard monitor checking both data streams in order.
module tb_io_port;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ioW, ioR, out_ready, in_valid;
  logic [15:0]   wdata, in_data;
  logic [15:0]   rdata, out_data;
  logic          stall, out_valid, in_ready;
  logic [CW-1:0] tx_count, rx_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tx_model[$];
  logic [15:0] rx_model[$];
  logic [15:0] tx_sb[$];
  logic [15:0] rx_sb[$];

  io_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ioW(ioW), .ioR(ioR), .wdata(wdata),
    .rdata(rdata), .stall(stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: checks every word the DUT actually hands over
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (tx_sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_stream at %0t: got %h expected nothing", $time, out_data);
        end else chk("tx_stream", 32'(out_data), 32'(tx_sb.pop_front()));
      end
      if (ioR && !stall) begin
        if (rx_sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_stream at %0t: got %h expected nothing", $time, rdata);
        end else chk("rx_stream", 32'(rdata), 32'(rx_sb.pop_front()));
      end
    end
  end

  // One clock cycle: drive, check against model, advance model, cross edge
  task automatic cycle(input logic w, input logic [15:0] wd, input logic r,
                       input logic ordy, input logic iv, input logic [15:0] id);
    logic st;
    int   tn, rn;
    ioW = w; wdata = wd; ioR = r; out_ready = ordy; in_valid = iv; in_data = id;
    #1;
    tn = tx_model.size();
    rn = rx_model.size();
    st = (w && tn == DEPTH) || (r && rn == 0);
    chk("stall",     32'(stall),     32'(st));
    chk("tx_count",  32'(tx_count),  32'(tn));
    chk("rx_count",  32'(rx_count),  32'(rn));
    chk("out_valid", 32'(out_valid), 32'(tn != 0));
    chk("in_ready",  32'(in_ready),  32'(rn != DEPTH));
    if (tn != 0) chk("out_data", 32'(out_data), 32'(tx_model[0]));
    if (rn != 0) chk("rdata", 32'(rdata), 32'(rx_model[0]));
    else         chk("rdata_empty", 32'(rdata), 32'h0);
    if (ordy && tn != 0) void'(tx_model.pop_front());
    if (w && !st) begin tx_model.push_back(wd); tx_sb.push_back(wd); end
    if (r && !st) void'(rx_model.pop_front());
    if (iv && rn != DEPTH) begin rx_model.push_back(id); rx_sb.push_back(id); end
    @(posedge clk); #1;
  endtask

  // Reset asserted between edges; effects must be visible before the next edge
  task automatic do_reset();
    ioW = 0; ioR = 0; out_ready = 0; in_valid = 0; wdata = '0; in_data = '0;
    rst_n = 0;
    #1;
    chk("rst_tx_count",  32'(tx_count),  32'h0);
    chk("rst_rx_count",  32'(rx_count),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_rdata",     32'(rdata),     32'h0);
    chk("rst_stall_idle", 32'(stall),    32'h0);
    ioR = 1;
    #1;
    chk("rst_stall_ior", 32'(stall), 32'h1);
    ioR = 0;
    tx_model.delete(); rx_model.delete(); tx_sb.delete(); rx_sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    ioW = 0; ioR = 0; out_ready = 0; in_valid = 0; wdata = '0; in_data = '0;
    do_reset();

    // Single write becomes visible one cycle later
    cycle(1, 16'h1234, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // Fill TX, stall while full, pop does not unblock the same-cycle push
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0, 0, 0, 0);
    cycle(1, 16'h0005, 0, 0, 0, 0);
    cycle(1, 16'h0005, 0, 1, 0, 0);
    cycle(1, 16'h0005, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0, 0);

    // Read from empty RX stalls; captured word appears next cycle
    cycle(0, 0, 1, 0, 1, 16'hBEEF);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // TX full stalls an otherwise-ready RX read
    for (int i = 0; i < 4; i++) cycle(1, 16'(16'hA0 + i), 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 16'h0007);
    cycle(1, 16'h0009, 1, 0, 0, 0);
    cycle(1, 16'h0009, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0);

    // Steady push+pop through the pointer wrap
    cycle(1, 16'h0100, 0, 0, 0, 0);
    cycle(1, 16'h0101, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 16'(16'h0200 + i), 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);

    // Reset with queued words discards them
    for (int i = 0; i < 3; i++) cycle(1, 16'(16'h0300 + i), 0, 0, 1, 16'(16'h0400 + i));
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic, with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55, 16'($urandom));
    end

    // Drain both FIFOs so the scoreboard should end empty
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, rx_model.size() != 0, 1, 0, 0);
    chk("tx_sb_drained", 32'(tx_sb.size()), 32'h0);
    chk("rx_sb_drained", 32'(rx_sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
